// File: rtl/apple_field_pkg.sv
// rtl/apple_field_pkg.sv - shared slot state encoding and per-slot salt helper
package apple_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SEEK  = 2'd1,
    TEST  = 2'd2,
    READY = 2'd3
  } apple_state_e;

  localparam int SALT_MULT = 37;

  // Callers truncate the result to their rng width, giving k*37 mod 2^width.
  function automatic logic [31:0] salt(input int k);
    return 32'(k * SALT_MULT);
  endfunction

endpackage

// File: rtl/apple_field_if.sv
// rtl/apple_field_if.sv - snake segment stream, one segment per cycle, head first
interface apple_field_if #(
  parameter int X_BITS = 5,
  parameter int Y_BITS = 4
);

  logic [X_BITS-1:0] snake_x;
  logic [Y_BITS-1:0] snake_y;
  logic              snake_first;
  logic              snake_last;
  logic              snake_valid;

  modport master (
    output snake_x,
    output snake_y,
    output snake_first,
    output snake_last,
    output snake_valid
  );

  modport slave (
    input snake_x,
    input snake_y,
    input snake_first,
    input snake_last,
    input snake_valid
  );

endinterface

// File: rtl/apple_field_slot.sv
// rtl/apple_field_slot.sv - one apple slot: position registers plus LOAD/SEEK/TEST/READY FSM
module apple_slot
  import apple_pkg::*;
#(
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 4,
  parameter int X_MIN    = 1,
  parameter int X_MAX    = 20,
  parameter int Y_MIN    = 1,
  parameter int Y_MAX    = 11,
  parameter int STEP_X   = 11,
  parameter int STEP_Y   = 7,
  parameter int SLOT_IDX = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [X_BITS+Y_BITS-1:0] rng,
  input  logic [X_BITS-1:0]        snake_x,
  input  logic [Y_BITS-1:0]        snake_y,
  input  logic                     snake_first,
  input  logic                     snake_valid,
  input  logic                     overlap_in,
  output logic [X_BITS-1:0]        x,
  output logic [Y_BITS-1:0]        y,
  output logic                     ready,
  output logic                     eat,
  output logic                     active
);

  localparam int                   RW    = X_BITS + Y_BITS;
  localparam logic [RW-1:0]        SALT  = RW'(salt(SLOT_IDX));
  localparam logic [X_BITS-1:0]    X_LO  = X_BITS'(X_MIN);
  localparam logic [X_BITS-1:0]    X_HI  = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0]    Y_LO  = Y_BITS'(Y_MIN);
  localparam logic [Y_BITS-1:0]    Y_HI  = Y_BITS'(Y_MAX);
  localparam logic [X_BITS-1:0]    X_INC = X_BITS'(STEP_X);
  localparam logic [Y_BITS-1:0]    Y_INC = Y_BITS'(STEP_Y);

  apple_state_e      state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [RW-1:0]     seed;
  logic              pos_match;
  logic              hit;
  logic              x_oob;
  logic              y_oob;

  assign seed      = rng ^ SALT;
  assign pos_match = (snake_x == x_q) && (snake_y == y_q);
  assign hit       = snake_valid && pos_match;
  assign x_oob     = (x_q < X_LO) || (x_q > X_HI);
  assign y_oob     = (y_q < Y_LO) || (y_q > Y_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    eat     = snake_first && snake_valid && (state_q == READY) && pos_match;
    if (eat || (state_q == LOAD)) begin
      x_d     = seed[RW-1:Y_BITS];
      y_d     = seed[Y_BITS-1:0];
      state_d = SEEK;
    end else if (hit || x_oob || y_oob || overlap_in) begin
      // Step only the offending axis when one is out of range; both otherwise.
      state_d = SEEK;
      if (x_oob || !y_oob) x_d = x_q + X_INC;
      if (y_oob || !x_oob) y_d = y_q + Y_INC;
    end else if (snake_first && snake_valid) begin
      state_d = TEST;
    end else if (!snake_valid && (state_q == TEST)) begin
      state_d = READY;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign ready  = (state_q == READY);
  assign active = (state_q != LOAD);

endmodule

// File: rtl/apple_field.sv
// rtl/apple_field.sv - NUM_APPLES apple slots on the snake board, eat detection and packing
// Optional APPLE_OVERLAP_CHECK_EN: higher slots relocate off cells held by lower active slots.
module apple_field
  import apple_pkg::*;
#(
  parameter int NUM_APPLES = 3,
  parameter int X_BITS     = 5,
  parameter int Y_BITS     = 4,
  parameter int X_MIN      = 1,
  parameter int X_MAX      = 20,
  parameter int Y_MIN      = 1,
  parameter int Y_MAX      = 11,
  parameter int STEP_X     = 11,
  parameter int STEP_Y     = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [X_BITS+Y_BITS-1:0]       i_rng,
  apple_field_if.slave                   snake,
  output logic [NUM_APPLES*X_BITS-1:0]   o_apple_x,
  output logic [NUM_APPLES*Y_BITS-1:0]   o_apple_y,
  output logic [NUM_APPLES-1:0]          o_ready,
  output logic [NUM_APPLES-1:0]          o_eat,
  output logic                           o_eat_any
);

  logic [X_BITS-1:0]     slot_x [NUM_APPLES];
  logic [Y_BITS-1:0]     slot_y [NUM_APPLES];
  logic [NUM_APPLES-1:0] active;
  logic [NUM_APPLES-1:0] overlap;
  logic                  unused_last;

  // The tail marker is kept on the bus for scan bookkeeping but does not steer the slots.
  assign unused_last = snake.snake_last;

`ifdef APPLE_OVERLAP_CHECK_EN
  always_comb begin
    overlap = '0;
    for (int k = 1; k < NUM_APPLES; k++) begin
      for (int j = 0; j < k; j++) begin
        if (active[j] && (slot_x[k] == slot_x[j]) && (slot_y[k] == slot_y[j])) begin
          overlap[k] = 1'b1;
        end
      end
    end
  end
`else
  assign overlap = '0;
`endif

  for (genvar k = 0; k < NUM_APPLES; k++) begin : g_slot
    apple_slot #(
      .X_BITS   (X_BITS),
      .Y_BITS   (Y_BITS),
      .X_MIN    (X_MIN),
      .X_MAX    (X_MAX),
      .Y_MIN    (Y_MIN),
      .Y_MAX    (Y_MAX),
      .STEP_X   (STEP_X),
      .STEP_Y   (STEP_Y),
      .SLOT_IDX (k)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .rng         (i_rng),
      .snake_x     (snake.snake_x),
      .snake_y     (snake.snake_y),
      .snake_first (snake.snake_first),
      .snake_valid (snake.snake_valid),
      .overlap_in  (overlap[k]),
      .x           (slot_x[k]),
      .y           (slot_y[k]),
      .ready       (o_ready[k]),
      .eat         (o_eat[k]),
      .active      (active[k])
    );

    assign o_apple_x[k*X_BITS +: X_BITS] = slot_x[k];
    assign o_apple_y[k*Y_BITS +: Y_BITS] = slot_y[k];
  end

  assign o_eat_any = |o_eat;

endmodule

// File: tb/tb_apple_field.sv
// tb/tb_apple_field.sv - directed scoreboard bench for apple_field
module tb_apple_field;

  localparam int N  = 3;
  localparam int XB = 5;
  localparam int YB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8:0]      rng;
  logic [N*XB-1:0] ax;
  logic [N*YB-1:0] ay;
  logic [N-1:0]    ready;
  logic [N-1:0]    eat;
  logic            eat_any;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  apple_field_if #(.X_BITS(XB), .Y_BITS(YB)) snk ();

  apple_field dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rng     (rng),
    .snake     (snk),
    .o_apple_x (ax),
    .o_apple_y (ay),
    .o_ready   (ready),
    .o_eat     (eat),
    .o_eat_any (eat_any)
  );

  function automatic logic [8:0] salt_m(input int k);
    logic [31:0] t;
    t = k * 37;
    return t[8:0];
  endfunction

  function automatic logic [31:0] sx(input int k);
    return 32'(ax[k*XB +: XB]);
  endfunction

  function automatic logic [31:0] sy(input int k);
    return 32'(ay[k*YB +: YB]);
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic [4:0] x, input logic [3:0] y);
    snk.snake_first = f;
    snk.snake_valid = v;
    snk.snake_x     = x;
    snk.snake_y     = y;
    snk.snake_last  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 4'd0);
  endtask

  task automatic reset_load(input logic [8:0] r);
    rst_n = 1'b0;
    rng   = r;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic expect_slot(input string tag, input int k, input logic [31:0] ex, input logic [31:0] ey);
    push({tag, "_x"}, ex);
    check(sx(k));
    push({tag, "_y"}, ey);
    check(sy(k));
  endtask

  task automatic expect_load(input string tag, input int k);
    logic [8:0] r;
    r = rng ^ salt_m(k);
    expect_slot(tag, k, 32'(r[8:4]), 32'(r[3:0]));
  endtask

  initial begin
    rst_n = 1'b1;
    rng   = 9'h055;
    idle();
    #1 rst_n = 1'b0;
    #1;
    push("rst_ready", 0);   check(32'(ready));
    push("rst_eat", 0);     check(32'(eat));
    push("rst_eat_any", 0); check(32'(eat_any));
    push("rst_x", 0);       check(32'(ax));
    push("rst_y", 0);       check(32'(ay));

    // First clock after release loads every slot from rng ^ salt.
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    expect_load("a_load0", 0);
    push("a_inbounds", 1);
    check(32'((sx(0) >= 1) && (sx(0) <= 20) && (sy(0) >= 1) && (sy(0) <= 11)));
    push("a_ready_load", 0); check(32'(ready));

    drive(1'b1, 1'b1, 5'd20, 4'd11);
    step();
    expect_slot("a_s1_walk", 1, 7, 7);
    expect_slot("a_s2_walk", 2, 1, 6);
    push("a_ready_test", 0); check(32'(ready));
    idle();
    step();
    push("a_ready_armed", 32'b001); check(32'(ready));

    // Head lands on ready slot 0.
    rng = 9'h074;
    drive(1'b1, 1'b1, 5'd5, 4'd5);
    #1;
    push("b_eat", 32'b001);  check(32'(eat));
    push("b_eat_any", 1);    check(32'(eat_any));
    step();
    push("b_ready_drop", 0); check(32'(ready));
    expect_load("b_reload0", 0);
    idle();
    step();
    push("b_ready_others", 32'b110); check(32'(ready));
    drive(1'b1, 1'b1, 5'd20, 4'd11);
    step();
    idle();
    step();
    push("b_all_ready", 32'b111); check(32'(ready));

    // Body segment covering a ready apple relocates it without an eat.
    drive(1'b0, 1'b1, 5'd7, 4'd4);
    #1;
    push("c_no_eat", 0); check(32'(eat));
    step();
    push("c_ready", 32'b110); check(32'(ready));
    expect_slot("c_reloc0", 0, 18, 11);

    // Asynchronous reset in the middle of a scan.
    drive(1'b1, 1'b1, 5'd20, 4'd11);
    step();
    idle();
    step();
    push("d_all_ready", 32'b111); check(32'(ready));
    drive(1'b1, 1'b1, 5'd7, 4'd7);
    #1;
    push("d_eat_pre", 32'b010); check(32'(eat));
    #1 rst_n = 1'b0;
    #1;
    push("d_ready", 0);   check(32'(ready));
    push("d_eat", 0);     check(32'(eat));
    push("d_eat_any", 0); check(32'(eat_any));
    push("d_x", 0);       check(32'(ax));
    push("d_y", 0);       check(32'(ay));
    reset_load(9'h0A5);
    for (int k = 0; k < N; k++) expect_load($sformatf("d_load%0d", k), k);
    push("d_ready_load", 0); check(32'(ready));

    // Out-of-bounds walks.
    idle();
    reset_load(9'h00C);
    expect_load("e_load_corner", 0);
    step();
    expect_slot("e_both_oob", 0, 11, 3);
    reset_load(9'h155);
    expect_load("e_load_xoob", 0);
    step();
    expect_slot("e_x_wrap", 0, 0, 5);
    step();
    expect_slot("e_x_again", 0, 11, 5);

    // Slot 0 reloads onto slot 1's cell.
    reset_load(9'h016);
    expect_slot("f_s1_load", 1, 3, 3);
    drive(1'b1, 1'b1, 5'd20, 4'd11);
    step();
    idle();
    step();
    push("f_ready", 32'b011); check(32'(ready));
    rng = 9'h033;
    drive(1'b1, 1'b1, 5'd1, 4'd6);
    #1;
    push("f_eat0", 32'b001); check(32'(eat));
    step();
    idle();
    step();
`ifdef APPLE_OVERLAP_CHECK_EN
    expect_slot("f_s0_keep", 0, 3, 3);
    expect_slot("f_s1_step", 1, 14, 10);
`else
    expect_slot("f_s0_share", 0, 3, 3);
    expect_slot("f_s1_share", 1, 3, 3);
    drive(1'b1, 1'b1, 5'd20, 4'd11);
    step();
    idle();
    step();
    drive(1'b1, 1'b1, 5'd3, 4'd3);
    #1;
    push("f_double_eat", 32'b011); check(32'(eat));
    push("f_double_any", 1);       check(32'(eat_any));
`endif
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
